// File: rtl/i2c_txn_scheduler.sv
// i2c_txn_scheduler: shares one I2C master among NREQ requesters.
// Round-robin arbitration with optional bus lock (repeated start), an
// EEPROM write-cycle guard after write transactions, and a per-transaction
// watchdog. All outputs are registered.
module i2c_txn_scheduler #(
  parameter int unsigned NREQ           = 8,
  parameter int unsigned IDW            = 3,
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned GUARD_CYCLES   = 600000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic            clock,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  input  logic [NREQ-1:0] wr_flag,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            m_start,
  input  logic            m_done,
  input  logic            m_err,
  output logic            m_abort,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] err,
  output logic            busy,
  output logic            guard_active
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_RELEASE = 3'd3,
    S_GUARD   = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic             TMO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic             GUARD_EN   = (GUARD_CYCLES != 0);

  // Parameter sanity: reject configurations the counters/index cannot hold
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("i2c_txn_scheduler: NREQ must be in 2..16");
  end
  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("i2c_txn_scheduler: IDW must equal clog2(NREQ)");
  end
  if (64'(GUARD_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_guard
    $error("i2c_txn_scheduler: GUARD_CYCLES does not fit in CNT_W");
  end
  if (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_tmo
    $error("i2c_txn_scheduler: TIMEOUT_CYCLES does not fit in CNT_W");
  end

  state_t           state, state_n;
  logic [IDW-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             wr_q, wr_n;
  logic             guard_arm;

  logic [NREQ-1:0]  gnt_n, done_n, err_n;
  logic [IDW-1:0]   gnt_id_n;
  logic             m_start_n, m_abort_n, busy_n, guard_n;

  logic [IDW-1:0]   pick_id;
  logic             pick_vld;

  // Index base+off folded back into 0..NREQ-1
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                               input int unsigned    off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  assign guard_arm = wr_q & GUARD_EN;

  // Round-robin pick: first active request scanning upward from ptr
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!pick_vld && req[wrap_idx(ptr, i)]) begin
        pick_vld = 1'b1;
        pick_id  = wrap_idx(ptr, i);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    wr_n      = wr_q;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    guard_n   = guard_active;
    m_start_n = 1'b0;
    m_abort_n = 1'b0;
    done_n    = '0;
    err_n     = '0;

    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_n    = NREQ'(1) << pick_id;
          gnt_id_n = pick_id;
          state_n  = S_START;
        end
      end

      S_START: begin
        m_start_n = 1'b1;
        wr_n      = wr_flag[gnt_id];
        cnt_n     = '0;
        state_n   = S_WAIT;
      end

      S_WAIT: begin
        if (m_done) begin
          done_n  = gnt;
          err_n   = m_err ? gnt : '0;
          state_n = S_RELEASE;
        end else if (TMO_EN && cnt == TMO_LAST) begin
          m_abort_n = 1'b1;
          done_n    = gnt;
          err_n     = gnt;
          state_n   = S_RELEASE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (guard_arm) begin
          cnt_n   = GUARD_LAST;
          guard_n = 1'b1;
        end
        if (lock[gnt_id]) begin
          state_n = guard_arm ? S_GUARD : S_HOLD;
        end else begin
          ptr_n    = wrap_idx(gnt_id, 1);
          gnt_n    = '0;
          gnt_id_n = '0;
          state_n  = guard_arm ? S_GUARD : S_IDLE;
        end
      end

      S_GUARD: begin
        // A kept grant means the owner was locked when the guard began
        if (cnt == '0) begin
          guard_n = 1'b0;
          state_n = (gnt != '0) ? S_HOLD : S_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (req[gnt_id]) begin
          state_n = S_START;
        end else if (!lock[gnt_id]) begin
          ptr_n    = wrap_idx(gnt_id, 1);
          gnt_n    = '0;
          gnt_id_n = '0;
          state_n  = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State, pointer, counter and output registers
  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      cnt          <= '0;
      wr_q         <= 1'b0;
      gnt          <= '0;
      gnt_id       <= '0;
      m_start      <= 1'b0;
      m_abort      <= 1'b0;
      done         <= '0;
      err          <= '0;
      busy         <= 1'b0;
      guard_active <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      cnt          <= cnt_n;
      wr_q         <= wr_n;
      gnt          <= gnt_n;
      gnt_id       <= gnt_id_n;
      m_start      <= m_start_n;
      m_abort      <= m_abort_n;
      done         <= done_n;
      err          <= err_n;
      busy         <= busy_n;
      guard_active <= guard_n;
    end
  end

endmodule
